// File: rtl/and_mon_pkg.sv
// rtl/and_mon_pkg.sv - shared state type and default widths for and_edge_monitor
package and_mon_pkg;

    typedef enum logic {
        ST_COUNT  = 1'b0,
        ST_REPORT = 1'b1
    } st_t;

    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - en-gated sampling of the AND result and registered rising-edge pulse
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic in_a_i,
    output logic s_a_o,
    output logic rise_o,
    output logic rise_pulse_o
);

    logic s_a_q;
    logic prev_a_q;
    logic pulse_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_a_q    <= 1'b0;
            prev_a_q <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            if (en_i) begin
                s_a_q    <= in_a_i;
                prev_a_q <= s_a_q;
            end
            pulse_q <= rise_o;
        end
    end

    // Gating with en keeps a held sample from re-firing while sampling is frozen.
    assign rise_o       = en_i & s_a_q & ~prev_a_q;
    assign s_a_o        = s_a_q;
    assign rise_pulse_o = pulse_q;

endmodule

// File: rtl/and_edge_monitor.sv
// rtl/and_edge_monitor.sv - edge counter and threshold report behind the AND block; MISMATCH_CHECK_EN adds the output-disagreement flag
module and_edge_monitor
    import and_mon_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_assign,
    input  logic             in_always,
    output logic             rise_pulse,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_count,
    output logic             mismatch
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

    st_t              state_q, state_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] rpt_count_q, rpt_count_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             s_a;
    logic             rise;

    rise_detect u_rise_detect (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en),
        .in_a_i       (in_assign),
        .s_a_o        (s_a),
        .rise_o       (rise),
        .rise_pulse_o (rise_pulse)
    );

    assign cnt_inc = (edge_cnt_q == CNT_MAX) ? CNT_MAX : edge_cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        edge_cnt_d  = edge_cnt_q;
        rpt_count_d = rpt_count_q;
        case (state_q)
            ST_COUNT: begin
                // ">=" lets THRESH=1 report again when a handshake left the count at 1.
                if (rise) begin
                    edge_cnt_d = cnt_inc;
                    if (cnt_inc >= THRESH_C) begin
                        state_d     = ST_REPORT;
                        rpt_count_d = THRESH_C;
                    end
                end
            end
            ST_REPORT: begin
                if (rpt_ready) begin
                    state_d    = ST_COUNT;
                    edge_cnt_d = rise ? CNT_W'(1) : '0;
                end else if (rise) begin
                    edge_cnt_d = cnt_inc;
                end
            end
            default: state_d = ST_COUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_COUNT;
            edge_cnt_q  <= '0;
            rpt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            edge_cnt_q  <= edge_cnt_d;
            rpt_count_q <= rpt_count_d;
        end
    end

    assign edge_cnt  = edge_cnt_q;
    assign rpt_count = rpt_count_q;
    assign rpt_valid = (state_q == ST_REPORT);

`ifdef MISMATCH_CHECK_EN
    logic s_b_q;
    logic mismatch_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_b_q      <= 1'b0;
            mismatch_q <= 1'b0;
        end else if (en) begin
            s_b_q      <= in_always;
            mismatch_q <= mismatch_q | (s_a ^ s_b_q);
        end
    end

    assign mismatch = mismatch_q;
`else
    logic unused_inputs;

    assign unused_inputs = in_always ^ s_a;
    assign mismatch      = 1'b0;
`endif

endmodule

// File: tb/tb_and_edge_monitor.sv
// tb/tb_and_edge_monitor.sv - table, directed and randomized checks of and_edge_monitor against a sample-history model
module tb_and_edge_monitor;

    localparam int CNT_W  = 8;
    localparam int THRESH = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;
`ifdef MISMATCH_CHECK_EN
    localparam bit MM_ON = 1'b1;
`else
    localparam bit MM_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, en, in_assign, in_always, rpt_ready;
    logic             rise_pulse, rpt_valid, mismatch;
    logic [CNT_W-1:0] edge_cnt, rpt_count;

    always #5 clk = ~clk;

    and_edge_monitor #(.CNT_W(CNT_W), .THRESH(THRESH)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_assign  (in_assign),
        .in_always  (in_always),
        .rise_pulse (rise_pulse),
        .edge_cnt   (edge_cnt),
        .rpt_valid  (rpt_valid),
        .rpt_ready  (rpt_ready),
        .rpt_count  (rpt_count),
        .mismatch   (mismatch)
    );

    int checks   = 0;
    int failures = 0;

    // Model: history of values taken on enabled edges, plus report bookkeeping.
    bit q_a[$];
    bit q_x[$];
    int m_cnt, m_rcount;
    bit m_valid, m_mm, m_pulse;

    typedef struct {
        bit a;
        bit exp_pulse;
        int exp_cnt;
        bit exp_valid;
        int exp_rcount;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit rise;
        if (rst) begin
            q_a.delete();
            q_x.delete();
            m_cnt = 0; m_rcount = 0; m_valid = 0; m_mm = 0; m_pulse = 0;
            return;
        end
        rise = en && q_a.size() >= 1 && q_a[$] && !(q_a.size() >= 2 && q_a[$-1]);
        if (MM_ON && en && q_x.size() >= 1 && q_x[$]) m_mm = 1;
        if (m_valid && rpt_ready) begin
            m_valid = 0;
            m_cnt   = rise ? 1 : 0;
        end else if (rise) begin
            m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            if (!m_valid && m_cnt >= THRESH) begin
                m_valid  = 1;
                m_rcount = THRESH;
            end
        end
        m_pulse = rise;
        if (en) begin
            q_a.push_back(in_assign);
            q_x.push_back(in_assign ^ in_always);
            if (q_a.size() > 4) begin
                void'(q_a.pop_front());
                void'(q_x.pop_front());
            end
        end
    endtask

    task automatic step(input bit r, input bit e, input bit a, input bit b, input bit rd);
        rst = r; en = e; in_assign = a; in_always = b; rpt_ready = rd;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("model_rise_pulse", int'(rise_pulse), int'(m_pulse));
        chk("model_edge_cnt",   int'(edge_cnt),   m_cnt);
        chk("model_rpt_valid",  int'(rpt_valid),  int'(m_valid));
        chk("model_rpt_count",  int'(rpt_count),  m_rcount);
        chk("model_mismatch",   int'(mismatch),   int'(m_mm));
    endtask

    task automatic pulse(input bit rd);
        step(0, 1, 1, 1, rd);
        step(0, 1, 0, 0, rd);
    endtask

    initial begin
        int base, npulse;
        // Pattern 1,1,0,0: a rise lands on every edge i with i%4==1.
        for (int i = 0; i < 16; i++) begin
            tbl[i].a          = (i % 4) < 2;
            tbl[i].exp_pulse  = (i % 4) == 1;
            tbl[i].exp_cnt    = (i + 3) / 4;
            tbl[i].exp_valid  = i >= 13;
            tbl[i].exp_rcount = (i >= 13) ? 4 : 0;
        end

        step(1, 1, 1, 0, 1);
        step(1, 1, 0, 1, 0);
        chk("reset_edge_cnt",  int'(edge_cnt),  0);
        chk("reset_rpt_valid", int'(rpt_valid), 0);
        chk("reset_mismatch",  int'(mismatch),  0);

        for (int i = 0; i < 16; i++) begin
            step(0, 1, tbl[i].a, tbl[i].a, 0);
            chk("tbl_rise_pulse", int'(rise_pulse), int'(tbl[i].exp_pulse));
            chk("tbl_edge_cnt",   int'(edge_cnt),   tbl[i].exp_cnt);
            chk("tbl_rpt_valid",  int'(rpt_valid),  int'(tbl[i].exp_valid));
            chk("tbl_rpt_count",  int'(rpt_count),  tbl[i].exp_rcount);
        end

        for (int i = 16; i < 26; i++) step(0, 1, (i % 4) < 2 && i < 24, (i % 4) < 2 && i < 24, 0);
        chk("hold_edge_cnt",  int'(edge_cnt),  6);
        chk("hold_rpt_valid", int'(rpt_valid), 1);
        chk("hold_rpt_count", int'(rpt_count), 4);
        step(0, 1, 0, 0, 1);
        chk("hs_rpt_valid", int'(rpt_valid), 0);
        chk("hs_edge_cnt",  int'(edge_cnt),  0);

        for (int i = 0; i < 4; i++) pulse(0);
        step(0, 1, 0, 0, 0);
        chk("rearm_rpt_valid", int'(rpt_valid), 1);
        step(0, 1, 1, 1, 0);
        step(0, 1, 1, 1, 1);
        chk("hs_rise_edge_cnt",  int'(edge_cnt),  1);
        chk("hs_rise_rpt_valid", int'(rpt_valid), 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("hs_rise_no_report", int'(rpt_valid), 0);

        for (int i = 0; i < 3; i++) pulse(0);
        for (int i = 0; i < 300; i++) pulse(0);
        chk("sat_edge_cnt",  int'(edge_cnt),  CMAX);
        chk("sat_rpt_count", int'(rpt_count), 4);
        step(0, 1, 0, 0, 1);
        chk("sat_hs_edge_cnt", int'(edge_cnt), 0);

        for (int i = 0; i < 4; i++) pulse(0);
        step(1, 1, 0, 0, 0);
        chk("rst_in_report_valid", int'(rpt_valid), 0);
        chk("rst_in_report_cnt",   int'(edge_cnt),  0);

        step(0, 1, 1, 0, 0);
        chk("mm_not_yet", int'(mismatch), 0);
        step(0, 1, 0, 0, 0);
        chk("mm_two_edges", int'(mismatch), int'(MM_ON));
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        chk("mm_sticky", int'(mismatch), int'(MM_ON));

        base = int'(edge_cnt);
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, i[0] == 1'b0, i[0] == 1'b0, 0);
            npulse += int'(rise_pulse);
        end
        chk("en_low_pulses", npulse, 0);
        chk("en_low_cnt", int'(edge_cnt), base);
        npulse = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 1, 0);
            npulse += int'(rise_pulse);
        end
        chk("en_rise_at_most_one", int'(npulse <= 1), 1);

        for (int i = 0; i < 2000; i++) begin
            bit a, b;
            a = ($urandom_range(0, 2) != 0);
            b = ($urandom_range(0, 19) == 0) ? ~a : a;
            step($urandom_range(0, 199) == 0, $urandom_range(0, 4) != 0, a, b,
                 $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
